// File: rtl/pbus_pkg.sv
// Shared definitions for the Pico-style 8-bit parallel bus: widths, default
// strobe timing (also used by the responder-side model) and initiator FSM states.
package pbus_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;

  localparam int unsigned SETUP_CYC   = 4;
  localparam int unsigned PULSE_CYC   = 8;
  localparam int unsigned HOLD_CYC    = 4;
  localparam int unsigned TIMEOUT_CYC = 1024;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SETUP      = 3'd1,
    ST_WR_PULSE   = 3'd2,
    ST_RD_WAIT    = 3'd3,
    ST_RD_RELEASE = 3'd4,
    ST_HOLD       = 3'd5
  } state_t;

  // Request latched at accept; addr/wdata drive the bus for the whole transaction.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pbus_sync2.sv
// Generic two-flop synchronizer, asynchronous reset to zero.
module pbus_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pbus_master.sv
// Pico-bus initiator: turns single-cycle requests into timed cs/wr/rd bus cycles,
// waiting on a synchronized rdy level for reads with a per-edge timeout.
module pbus_master
  import pbus_pkg::*;
#(
  parameter int unsigned P_SETUP_CYC   = SETUP_CYC,
  parameter int unsigned P_PULSE_CYC   = PULSE_CYC,
  parameter int unsigned P_HOLD_CYC    = HOLD_CYC,
  parameter int unsigned P_TIMEOUT_CYC = TIMEOUT_CYC
) (
  input  logic              clk20,
  input  logic              core_rst_n,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              cs_o,
  output logic              wr_o,
  output logic              rd_o,
  output logic [ADDR_W-1:0] a_o,
  output logic [DATA_W-1:0] d_w_o,
  input  logic [DATA_W-1:0] d_r_i,
  input  logic              rdy_i
);

  localparam int unsigned CNT_MAX = max3(P_SETUP_CYC, P_PULSE_CYC, P_HOLD_CYC);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned TCNT_W  = $clog2(P_TIMEOUT_CYC);

  state_t            state;
  req_t              cur;
  logic [CNT_W-1:0]  cnt;
  logic [TCNT_W-1:0] tcnt;
  logic [TCNT_W-1:0] tcnt_inc;
  logic              rdy_s;
  logic              tmo_hit;

  pbus_sync2 #(.WIDTH(1)) u_rdy_sync (
    .clk   (clk20),
    .rst_n (core_rst_n),
    .d     (rdy_i),
    .q     (rdy_s)
  );

  // Address and write data come straight from the latched request register.
  assign a_o   = cur.addr;
  assign d_w_o = cur.wdata;

  // Timeout fires on the edge where the wait count would reach TIMEOUT-1.
  assign tcnt_inc = tcnt + TCNT_W'(1);
  assign tmo_hit  = (tcnt_inc == TCNT_W'(P_TIMEOUT_CYC - 1));

  always_ff @(posedge clk20 or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state   <= ST_IDLE;
      cur     <= '0;
      cnt     <= '0;
      tcnt    <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      rdata_o <= '0;
      err_o   <= 1'b0;
      cs_o    <= 1'b0;
      wr_o    <= 1'b0;
      rd_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_i) begin
            cur.we   <= we_i;
            cur.addr <= addr_i;
            if (we_i) cur.wdata <= wdata_i;
            cs_o   <= 1'b1;
            busy_o <= 1'b1;
            err_o  <= 1'b0;
            cnt    <= CNT_W'(P_SETUP_CYC - 1);
            state  <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (cnt == '0) begin
            if (cur.we) begin
              wr_o  <= 1'b1;
              cnt   <= CNT_W'(P_PULSE_CYC - 1);
              state <= ST_WR_PULSE;
            end else begin
              rd_o  <= 1'b1;
              tcnt  <= '0;
              state <= ST_RD_WAIT;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        ST_WR_PULSE: begin
          if (cnt == '0) begin
            wr_o  <= 1'b0;
            cnt   <= CNT_W'(P_HOLD_CYC - 1);
            state <= ST_HOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        // d_r_i has been stable for two cycles by the time rdy_s is seen high.
        ST_RD_WAIT: begin
          if (rdy_s) begin
            rdata_o <= d_r_i;
            rd_o    <= 1'b0;
            tcnt    <= '0;
            state   <= ST_RD_RELEASE;
          end else if (tmo_hit) begin
            rd_o    <= 1'b0;
            err_o   <= 1'b1;
            rdata_o <= '0;
            cnt     <= CNT_W'(P_HOLD_CYC - 1);
            state   <= ST_HOLD;
          end else begin
            tcnt <= tcnt_inc;
          end
        end

        // Responder drops rdy after rd falls; wait for that before the hold phase.
        ST_RD_RELEASE: begin
          if (!rdy_s) begin
            cnt   <= CNT_W'(P_HOLD_CYC - 1);
            state <= ST_HOLD;
          end else if (tmo_hit) begin
            err_o <= 1'b1;
            cnt   <= CNT_W'(P_HOLD_CYC - 1);
            state <= ST_HOLD;
          end else begin
            tcnt <= tcnt_inc;
          end
        end

        ST_HOLD: begin
          if (cnt == '0) begin
            cs_o   <= 1'b0;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pbus_master.sv
// Directed bench for pbus_master with an in-bench register-file responder
// that stores on wr fall and answers reads with rdy a fixed delay after rd rise.
module tb_pbus_master;

  logic       clk20 = 1'b0;
  logic       core_rst_n;
  logic       req_i, we_i;
  logic [5:0] addr_i;
  logic [7:0] wdata_i;
  logic       busy_o, done_o, err_o, cs_o, wr_o, rd_o;
  logic [7:0] rdata_o, d_w_o, d_r_i;
  logic [5:0] a_o;
  logic       rdy_i;

  int tests = 0;
  int fails = 0;

  localparam int RDY_DLY = 5;
  logic [7:0] mem [64];
  bit         resp_en;
  int         rd_cnt;
  logic       wr_prev;

  always #25 clk20 = ~clk20;

  pbus_master dut (
    .clk20(clk20), .core_rst_n(core_rst_n), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o),
    .rdata_o(rdata_o), .err_o(err_o), .cs_o(cs_o), .wr_o(wr_o), .rd_o(rd_o),
    .a_o(a_o), .d_w_o(d_w_o), .d_r_i(d_r_i), .rdy_i(rdy_i)
  );

  // One clock step: sample 1ns after the rising edge, then update the responder.
  task automatic step();
    @(posedge clk20);
    #1;
    if (wr_prev && !wr_o) mem[a_o] = d_w_o;
    wr_prev = wr_o;
    if (resp_en && rd_o) begin
      if (rd_cnt < RDY_DLY) rd_cnt++;
      if (rd_cnt == RDY_DLY) begin
        d_r_i = mem[a_o];
        rdy_i = 1'b1;
      end
    end else begin
      rdy_i  = 1'b0;
      rd_cnt = 0;
    end
  endtask

  // Present a request for one edge; returns 1ns after the accepting edge E0.
  task automatic start_req(input logic we, input logic [5:0] addr, input logic [7:0] data);
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = data;
    step();
    req_i = 1'b0;
  endtask

  task automatic test_reset();
    core_rst_n = 1'b0;
    req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    d_r_i = '0; rdy_i = 1'b0; resp_en = 1'b1; rd_cnt = 0; wr_prev = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (3) step();
    tests++;
    if ({cs_o, wr_o, rd_o, busy_o, done_o, err_o, a_o, d_w_o, rdata_o} !== 31'd0) begin
      fails++;
      $display("FAIL reset_outputs got=%h exp=0",
               {cs_o, wr_o, rd_o, busy_o, done_o, err_o, a_o, d_w_o, rdata_o});
    end
    #10 core_rst_n = 1'b1;
    repeat (2) step();
    tests++;
    if (busy_o !== 1'b0 || cs_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle busy=%b cs=%b exp 0 0", busy_o, cs_o);
    end
  endtask

  task automatic test_write();
    logic exp_wr, exp_on;
    start_req(1'b1, 6'h05, 8'hA5);
    tests++;
    if (cs_o !== 1'b1 || busy_o !== 1'b1 || a_o !== 6'h05 || d_w_o !== 8'hA5 || wr_o !== 1'b0) begin
      fails++;
      $display("FAIL write_accept cs=%b busy=%b a=%h d=%h wr=%b exp 1 1 05 a5 0",
               cs_o, busy_o, a_o, d_w_o, wr_o);
    end
    for (int k = 1; k <= 17; k++) begin
      step();
      exp_wr = (k >= 4 && k <= 11);
      exp_on = (k < 16);
      tests++;
      if (wr_o !== exp_wr) begin
        fails++; $display("FAIL write_wr k=%0d got=%b exp=%b", k, wr_o, exp_wr);
      end
      tests++;
      if (done_o !== (k == 16)) begin
        fails++; $display("FAIL write_done k=%0d got=%b exp=%b", k, done_o, k == 16);
      end
      tests++;
      if (cs_o !== exp_on || busy_o !== exp_on) begin
        fails++; $display("FAIL write_cs_busy k=%0d cs=%b busy=%b exp=%b", k, cs_o, busy_o, exp_on);
      end
      tests++;
      if (a_o !== 6'h05 || d_w_o !== 8'hA5 || err_o !== 1'b0 || rd_o !== 1'b0) begin
        fails++;
        $display("FAIL write_bus k=%0d a=%h d=%h err=%b rd=%b exp 05 a5 0 0", k, a_o, d_w_o, err_o, rd_o);
      end
    end
    tests++;
    if (mem[5] !== 8'hA5) begin
      fails++; $display("FAIL write_loopback_mem got=%h exp=a5", mem[5]);
    end
  endtask

  task automatic test_read();
    logic exp_rd;
    mem[6'h12] = 8'h3C;
    resp_en = 1'b1;
    start_req(1'b0, 6'h12, 8'h00);
    tests++;
    if (a_o !== 6'h12 || d_w_o !== 8'hA5 || cs_o !== 1'b1) begin
      fails++; $display("FAIL read_accept a=%h d_w=%h cs=%b exp 12 a5 1", a_o, d_w_o, cs_o);
    end
    // rdy_i rises after E0+8, first seen at E0+9; rd falls at E0+11, done at E0+18
    for (int k = 1; k <= 19; k++) begin
      step();
      exp_rd = (k >= 4 && k <= 10);
      tests++;
      if (rd_o !== exp_rd || wr_o !== 1'b0) begin
        fails++; $display("FAIL read_rd k=%0d rd=%b wr=%b exp rd=%b wr=0", k, rd_o, wr_o, exp_rd);
      end
      tests++;
      if (done_o !== (k == 18)) begin
        fails++; $display("FAIL read_done k=%0d got=%b exp=%b", k, done_o, k == 18);
      end
      if (k == 18 || k == 19) begin
        tests++;
        if (rdata_o !== 8'h3C || err_o !== 1'b0) begin
          fails++; $display("FAIL read_data k=%0d rdata=%h err=%b exp 3c 0", k, rdata_o, err_o);
        end
      end
    end
  endtask

  task automatic test_timeout();
    resp_en = 1'b0;
    start_req(1'b0, 6'h21, 8'h00);
    for (int k = 1; k <= 1032; k++) begin
      step();
      if (k == 1026) begin
        tests++;
        if (rd_o !== 1'b1 || busy_o !== 1'b1 || rdata_o !== 8'h3C || err_o !== 1'b0) begin
          fails++;
          $display("FAIL tmo_before rd=%b busy=%b rdata=%h err=%b exp 1 1 3c 0", rd_o, busy_o, rdata_o, err_o);
        end
      end
      if (k == 1027) begin
        tests++;
        if (rd_o !== 1'b0 || err_o !== 1'b1 || rdata_o !== 8'h00 || done_o !== 1'b0) begin
          fails++;
          $display("FAIL tmo_fire rd=%b err=%b rdata=%h done=%b exp 0 1 00 0", rd_o, err_o, rdata_o, done_o);
        end
      end
      if (k == 1031) begin
        tests++;
        if (done_o !== 1'b1 || err_o !== 1'b1 || rdata_o !== 8'h00 || cs_o !== 1'b0) begin
          fails++;
          $display("FAIL tmo_done done=%b err=%b rdata=%h cs=%b exp 1 1 00 0", done_o, err_o, rdata_o, cs_o);
        end
      end
      if (k == 1032) begin
        tests++;
        if (done_o !== 1'b0 || cs_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b1) begin
          fails++;
          $display("FAIL tmo_after done=%b cs=%b busy=%b err=%b exp 0 0 0 1", done_o, cs_o, busy_o, err_o);
        end
      end
    end
    resp_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    int k, overlap;
    bit seen;
    overlap = 0;
    start_req(1'b1, 6'h2A, 8'h5A);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 40) begin
      step(); k++;
      if (wr_o && rd_o) overlap++;
      if (done_o) seen = 1'b1;
    end
    tests++;
    if (!seen || k != 16 || cs_o !== 1'b0) begin
      fails++; $display("FAIL b2b_write_done seen=%b k=%0d cs=%b exp 1 16 0", seen, k, cs_o);
    end
    start_req(1'b0, 6'h2A, 8'h00);
    tests++;
    if (cs_o !== 1'b1 || busy_o !== 1'b1 || err_o !== 1'b0) begin
      fails++; $display("FAIL b2b_reaccept cs=%b busy=%b err=%b exp 1 1 0", cs_o, busy_o, err_o);
    end
    seen = 1'b0;
    k = 0;
    while (!seen && k < 40) begin
      step(); k++;
      if (wr_o && rd_o) overlap++;
      if (done_o) seen = 1'b1;
    end
    tests++;
    if (!seen || k != 18 || rdata_o !== 8'h5A || err_o !== 1'b0) begin
      fails++;
      $display("FAIL b2b_read_done seen=%b k=%0d rdata=%h err=%b exp 1 18 5a 0", seen, k, rdata_o, err_o);
    end
    tests++;
    if (overlap != 0) begin
      fails++; $display("FAIL b2b_overlap got=%0d exp=0", overlap);
    end
  endtask

  task automatic test_busy();
    int dones, a_bad;
    dones = 0;
    a_bad = 0;
    start_req(1'b1, 6'h11, 8'h77);
    for (int k = 1; k <= 22; k++) begin
      step();
      if (done_o) dones++;
      if (a_o !== 6'h11 || d_w_o !== 8'h77) a_bad++;
      if (k == 6 || k == 15) begin
        req_i = 1'b1; we_i = 1'b0; addr_i = (k == 6) ? 6'h3F : 6'h3E;
      end else begin
        req_i = 1'b0;
      end
      if (k == 16) begin
        tests++;
        if (done_o !== 1'b1) begin
          fails++; $display("FAIL busy_done_at16 got=%b exp=1", done_o);
        end
      end
    end
    tests++;
    if (dones != 1) begin
      fails++; $display("FAIL busy_done_count got=%0d exp=1", dones);
    end
    tests++;
    if (a_bad != 0) begin
      fails++; $display("FAIL busy_bus_changed got=%0d exp=0", a_bad);
    end
    tests++;
    if (busy_o !== 1'b0 || cs_o !== 1'b0) begin
      fails++; $display("FAIL busy_idle_after busy=%b cs=%b exp 0 0", busy_o, cs_o);
    end
  endtask

  task automatic test_reset_mid_read();
    int k;
    bit seen;
    resp_en = 1'b0;
    start_req(1'b0, 6'h05, 8'h00);
    repeat (8) step();
    tests++;
    if (rd_o !== 1'b1) begin
      fails++; $display("FAIL rst_mid_in_wait rd=%b exp=1", rd_o);
    end
    #5 core_rst_n = 1'b0;
    #1;
    tests++;
    if ({cs_o, wr_o, rd_o, busy_o, done_o, err_o, a_o, d_w_o, rdata_o} !== 31'd0) begin
      fails++;
      $display("FAIL rst_mid_async got=%h exp=0",
               {cs_o, wr_o, rd_o, busy_o, done_o, err_o, a_o, d_w_o, rdata_o});
    end
    repeat (2) step();
    #10 core_rst_n = 1'b1;
    resp_en = 1'b1;
    step();
    start_req(1'b0, 6'h05, 8'h00);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 40) begin
      step(); k++;
      if (done_o) seen = 1'b1;
    end
    tests++;
    if (!seen || k != 18 || rdata_o !== 8'hA5 || err_o !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_fresh_read seen=%b k=%0d rdata=%h err=%b exp 1 18 a5 0", seen, k, rdata_o, err_o);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_back_to_back();
    test_busy();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
